mul_div_unit: RTL

- Iterative multiply/divide unit producing the HI/LO pair for MIPS mult, multu, div, divu, mthi and mtlo.
- Sits beside the single-cycle ALU in EX. It takes the same A/B operand buses and is steered by its own MDUCtl code from the control decoder.
- Uses a start/busy/done handshake so the pipeline stalls on mfhi/mflo while Busy is high.
- Radix-2 shift-add multiply and restoring divide on operand magnitudes, with a sign fix-up at the end.

---
 rtl/mul_div_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit that produces the HI/LO pair for the MIPS
// mult, multu, div, divu, mthi and mtlo instructions. It sits beside the ALU
// in EX and uses a start/busy/done handshake. A multiply or divide takes
// 34 busy cycles: PREP (1 cycle), RUN (WIDTH cycles) and FIX (1 cycle).
// Multiply is radix-2 shift-add and divide is restoring. Both work on the
// operand magnitudes, and the sign is fixed up at the end.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   Start   in   sample MDUCtl/A/B at this edge when idle
//   MDUCtl  in   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
//   A       in   rs operand (multiplicand / dividend / mthi-mtlo source)
//   B       in   rt operand (multiplier / divisor)
//   Busy    out  iterative operation in progress
//   Done    out  one-cycle pulse, Hi/Lo hold a new result
//   Hi      out  HI register
//   Lo      out  LO register
module mul_div_unit #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   DIVZ_QUOT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       MDUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]   cnt_q;
    logic            is_div_q;
    logic            is_signed_q;
    logic [WIDTH-1:0] a_q;          // raw A, also the Hi value on divide by zero
    logic [WIDTH-1:0] b_q;
    // mag_q holds the multiplicand for a multiply or the divisor for a divide.
    logic [WIDTH-1:0] mag_q;
    // acc_q is the product accumulator for a multiply, or {remainder, quotient}
    // for a divide.
    logic [W2-1:0]   acc_q;
    logic            neg_main_q;   // product / quotient sign
    logic            neg_rem_q;    // remainder sign
    logic            divz_q;

    logic [WIDTH-1:0] mag_a_d;
    logic [WIDTH-1:0] mag_b_d;
    logic [WIDTH:0]   mul_sum_d;
    logic [W2-1:0]    mul_acc_d;
    logic [WIDTH:0]   rem_sh_d;
    logic [WIDTH-1:0] rem_diff_d;
    logic [W2-1:0]    div_acc_d;
    logic [W2-1:0]    prod_fix_d;
    logic [WIDTH-1:0] quot_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    always_comb begin
        mag_a_d = (is_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b_d = (is_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;

        // Multiply step: conditionally add the multiplicand into the upper
        // half (keeping the carry), then shift the whole accumulator right.
        mul_sum_d = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mag_q};
        if (acc_q[0]) begin
            mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
        end else begin
            mul_acc_d = {1'b0, acc_q[W2-1:1]};
        end

        // Divide step: the shifted partial remainder can need WIDTH+1 bits.
        // When the trial subtract succeeds, the difference is below the
        // divisor, so the low WIDTH bits of the subtraction are exact.
        rem_sh_d   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff_d = rem_sh_d[WIDTH-1:0] - mag_q;
        if (rem_sh_d >= {1'b0, mag_q}) begin
            div_acc_d = {rem_diff_d, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_d = {rem_sh_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix_d = neg_main_q ? -acc_q : acc_q;
        quot_fix_d = neg_main_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_d  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mag_q       <= '0;
            acc_q       <= '0;
            neg_main_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        case (MDUCtl)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div_q    <= MDUCtl[1];
                                is_signed_q <= ~MDUCtl[0];
                                a_q         <= A;
                                b_q         <= B;
                                busy_q      <= 1'b1;
                                state_q     <= S_PREP;
                            end
                            3'b100:  hi_q <= A;
                            3'b101:  lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_PREP: begin
                    // For a multiply, the low half of the accumulator starts
                    // with the multiplier. For a divide, it starts with the
                    // dividend. The upper half always starts cleared.
                    if (is_div_q) begin
                        mag_q <= mag_b_d;
                        acc_q <= {{WIDTH{1'b0}}, mag_a_d};
                    end else begin
                        mag_q <= mag_a_d;
                        acc_q <= {{WIDTH{1'b0}}, mag_b_d};
                    end
                    neg_main_q <= is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_q  <= is_signed_q & a_q[WIDTH-1];
                    divz_q     <= is_div_q & (b_q == '0);
                    cnt_q      <= '0;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    acc_q <= is_div_q ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (divz_q) begin
                        lo_q <= DIVZ_QUOT;
                        hi_q <= a_q;
                    end else if (is_div_q) begin
                        lo_q <= quot_fix_d;
                        hi_q <= rem_fix_d;
                    end else begin
                        hi_q <= prod_fix_d[W2-1:WIDTH];
                        lo_q <= prod_fix_d[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
